golden_nonce_collector: RTL and testbench

- Sits directly upstream of the JTAG comm block; collects golden nonces from NUM_CORES hashing cores.
- Buffers nonces and presents them one at a time as a single-cycle pulse plus a held 32-bit value.
- Spaces pulses so the comm block never receives one while it is still serialising the previous nonce into its JTAG FIFO.
- Applies a fixed pipeline-latency correction to each nonce.

---
 rtl/golden_nonce_collector_pkg.sv | 21 ++
 rtl/golden_nonce_collector_if.sv | 26 ++
 rtl/golden_nonce_collector_fifo.sv | 50 +++++
 rtl/golden_nonce_collector.sv | 152 +++++++++++++++
 tb/tb_golden_nonce_collector.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/golden_nonce_collector_pkg.sv
// Shared definitions for the golden nonce collector: nonce width, output FSM
// state encoding and a ceil-log2 helper for pointer/level widths.
package golden_nonce_collector_pkg;

   localparam int NONCE_W = 32;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } tx_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int w = 0; w < 31; w++) begin
         if ((1 << w) < value) result = w + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/golden_nonce_collector_if.sv
// Core-facing strobes/nonces plus the comm-block facing output and status.
// master = the side producing nonces and consuming tx/status, slave = collector.
interface golden_nonce_collector_if
   import golden_nonce_collector_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int DEPTH     = 8
);
   logic [NUM_CORES-1:0]         in_new_nonce;
   logic [NONCE_W*NUM_CORES-1:0] in_golden_nonce;
   logic                         tx_busy;
   logic                         tx_new_nonce;
   logic [NONCE_W-1:0]           tx_golden_nonce;
   logic [7:0]                   drop_count;
   logic [clog2(DEPTH):0]        fifo_level;

   modport master (
      output in_new_nonce, in_golden_nonce, tx_busy,
      input  tx_new_nonce, tx_golden_nonce, drop_count, fifo_level
   );

   modport slave (
      input  in_new_nonce, in_golden_nonce, tx_busy,
      output tx_new_nonce, tx_golden_nonce, drop_count, fifo_level
   );
endinterface

// File: rtl/golden_nonce_collector_fifo.sv
// Synchronous circular FIFO of nonces. Push is refused when full and pop is
// refused when empty, both judged on the level at the start of the cycle.
module nonce_fifo
   import golden_nonce_collector_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [NONCE_W-1:0]      push_data,
   input  logic                    pop,
   output logic [NONCE_W-1:0]      head,
   output logic [clog2(DEPTH):0]   level,
   output logic                    full,
   output logic                    empty
);
   localparam int AW = clog2(DEPTH);

   logic [NONCE_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // storage array; contents are don't-care after reset because pointers clear
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      level <= level + (AW+1)'(1);
         else if (do_pop && !do_push) level <= level - (AW+1)'(1);
      end
   end
endmodule

// File: rtl/golden_nonce_collector.sv
// Golden nonce collector: per-core capture slots, round-robin arbiter into a
// central FIFO, and an output FSM that spaces strobes to the JTAG comm block.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | waiting for a buffered nonce and tx_busy low
//  ST_HOLD | strobe just issued; counting down HOLDOFF idle cycles
module golden_nonce_collector
   import golden_nonce_collector_pkg::*;
#(
   parameter int                 NUM_CORES = 4,
   parameter int                 DEPTH     = 8,
   parameter int                 HOLDOFF   = 8,
   parameter logic [NONCE_W-1:0] NONCE_ADJ = '0
) (
   input  logic                     hash_clk,
   input  logic                     rst_n,
   golden_nonce_collector_if.slave  bus
);
   localparam int LVL_W  = clog2(DEPTH) + 1;
   localparam int CORE_W = (NUM_CORES > 1) ? clog2(NUM_CORES) : 1;
   localparam int CNT_W  = clog2(HOLDOFF + 1);

   logic [NONCE_W-1:0]   slot_val [NUM_CORES];
   logic [NUM_CORES-1:0] slot_pend;
   logic [NUM_CORES-1:0] drop_mask;
   logic [CORE_W-1:0]    rr_ptr;
   logic                 grant_valid;
   logic [CORE_W-1:0]    grant_idx;
   logic [4:0]           drop_hits;
   logic [8:0]           drop_sum;
   logic [7:0]           drop_count;

   logic [NONCE_W-1:0]   fifo_head;
   logic [LVL_W-1:0]     fifo_level;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;

   tx_state_t            state, state_next;
   logic [CNT_W-1:0]     hold_cnt, cnt_next;
   logic                 tx_new_q, tx_new_next;
   logic [NONCE_W-1:0]   tx_val_q, tx_val_next;

   // round-robin search for the first pending slot at or after rr_ptr
   always_comb begin
      int idx;
      grant_valid = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      if (!fifo_full) begin
         for (int off = 0; off < NUM_CORES; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!grant_valid && slot_pend[idx]) begin
               grant_valid = 1'b1;
               grant_idx   = CORE_W'(idx);
            end
         end
      end
   end

   // a strobe is lost only if its slot is still occupied after this edge's grant
   always_comb begin
      drop_hits = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         drop_mask[i] = bus.in_new_nonce[i] & slot_pend[i]
                        & ~(grant_valid & (grant_idx == CORE_W'(i)));
         drop_hits    = drop_hits + 5'(drop_mask[i]);
      end
      drop_sum = {1'b0, drop_count} + 9'(drop_hits);
   end

   // capture slots, round-robin pointer and saturating drop counter
   always_ff @(posedge hash_clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_pend  <= '0;
         rr_ptr     <= '0;
         drop_count <= '0;
         for (int i = 0; i < NUM_CORES; i++) slot_val[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (bus.in_new_nonce[i] && !drop_mask[i]) begin
               slot_val[i]  <= bus.in_golden_nonce[NONCE_W*i +: NONCE_W];
               slot_pend[i] <= 1'b1;
            end else if (grant_valid && grant_idx == CORE_W'(i)) begin
               slot_pend[i] <= 1'b0;
            end
         end
         if (grant_valid)
            rr_ptr <= (grant_idx == CORE_W'(NUM_CORES - 1)) ? '0 : grant_idx + CORE_W'(1);
         drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   nonce_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (hash_clk),
      .rst_n     (rst_n),
      .push      (grant_valid),
      .push_data (slot_val[grant_idx]),
      .pop       (pop),
      .head      (fifo_head),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // output FSM state and registered outputs
   always_ff @(posedge hash_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         hold_cnt <= '0;
         tx_new_q <= 1'b0;
         tx_val_q <= '0;
      end else begin
         state    <= state_next;
         hold_cnt <= cnt_next;
         tx_new_q <= tx_new_next;
         tx_val_q <= tx_val_next;
      end
   end

   // next-state: pop and strobe from IDLE, then sit out HOLDOFF cycles
   always_comb begin
      state_next  = state;
      cnt_next    = hold_cnt;
      tx_new_next = 1'b0;
      tx_val_next = tx_val_q;
      pop         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && !bus.tx_busy) begin
               pop         = 1'b1;
               tx_new_next = 1'b1;
               tx_val_next = fifo_head - NONCE_ADJ;
               cnt_next    = CNT_W'(HOLDOFF);
               state_next  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            cnt_next = hold_cnt - CNT_W'(1);
            if (hold_cnt == CNT_W'(1)) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign bus.tx_new_nonce    = tx_new_q;
   assign bus.tx_golden_nonce = tx_val_q;
   assign bus.drop_count      = drop_count;
   assign bus.fifo_level      = fifo_level;
endmodule

// File: tb/tb_golden_nonce_collector.sv
// Bench for golden_nonce_collector: queue-based reference model predicts each
// edge; a negedge monitor compares strobes, values, drop count and FIFO level.
module tb_golden_nonce_collector;
   import golden_nonce_collector_pkg::*;

   localparam int          NC  = 4;
   localparam int          DP  = 8;
   localparam int          HO  = 8;
   localparam logic [31:0] ADJ = 32'h80;

   logic hash_clk = 1'b0;
   logic rst_n    = 1'b0;
   always #5 hash_clk = ~hash_clk;

   golden_nonce_collector_if #(.NUM_CORES(NC), .DEPTH(DP)) bus();

   golden_nonce_collector #(.NUM_CORES(NC), .DEPTH(DP), .HOLDOFF(HO), .NONCE_ADJ(ADJ)) dut (
      .hash_clk (hash_clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model state
   bit          m_pend [NC];
   logic [31:0] m_val  [NC];
   int          m_rr;
   logic [31:0] m_fifo [$];
   int          m_hold;
   bit          m_pulse;
   int          m_drop;
   logic [31:0] exp_q  [$];

   // observed output log for directed checks
   logic [31:0] pulse_log [$];
   int          pulse_cyc [$];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_pend[i] = 1'b0;
         m_val[i]  = '0;
      end
      m_rr    = 0;
      m_fifo.delete();
      m_hold  = 0;
      m_pulse = 1'b0;
      m_drop  = 0;
      exp_q.delete();
   endtask

   function automatic bit model_active();
      bit a;
      a = (m_fifo.size() > 0) || (m_hold > 0);
      for (int i = 0; i < NC; i++) a = a | m_pend[i];
      return a;
   endfunction

   // one rising edge of behaviour, using the inputs currently driven
   task automatic model_step();
      int lvl0;
      int g;
      int c;
      bit pend0 [NC];
      lvl0 = m_fifo.size();
      g    = -1;
      for (int i = 0; i < NC; i++) pend0[i] = m_pend[i];
      m_pulse = 1'b0;
      if (m_hold > 0) begin
         m_hold--;
      end else if (lvl0 > 0 && !bus.tx_busy) begin
         exp_q.push_back(m_fifo.pop_front() - ADJ);
         m_hold  = HO;
         m_pulse = 1'b1;
      end
      if (lvl0 < DP) begin
         for (int k = 0; k < NC; k++) begin
            c = (m_rr + k) % NC;
            if (g < 0 && pend0[c]) g = c;
         end
      end
      if (g >= 0) begin
         m_fifo.push_back(m_val[g]);
         m_pend[g] = 1'b0;
         m_rr      = (g + 1) % NC;
      end
      for (int i = 0; i < NC; i++) begin
         if (bus.in_new_nonce[i]) begin
            if (!pend0[i] || g == i) begin
               m_val[i]  = bus.in_golden_nonce[32*i +: 32];
               m_pend[i] = 1'b1;
            end else if (m_drop < 255) begin
               m_drop++;
            end
         end
      end
   endtask

   // drive one cycle of inputs, predict the edge, return just after next negedge
   task automatic cycle(input logic [NC-1:0] strb, input logic [32*NC-1:0] vals, input logic busy);
      bus.in_new_nonce    = strb;
      bus.in_golden_nonce = vals;
      bus.tx_busy         = busy;
      if (rst_n) model_step();
      @(negedge hash_clk);
      #1;
   endtask

   task automatic idle(input int n, input logic busy);
      for (int k = 0; k < n; k++) cycle('0, '0, busy);
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (model_active() && n < budget) begin
         cycle('0, '0, 1'b0);
         n++;
      end
      idle(2, 1'b0);
      check32({name, "_drain_done"}, 32'(model_active()), 32'd0);
      check32({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      bus.in_new_nonce = '0;
      bus.in_golden_nonce = '0;
      bus.tx_busy = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check32("rst_tx_new", 32'(bus.tx_new_nonce), 32'd0);
      check32("rst_tx_val", bus.tx_golden_nonce, 32'd0);
      check32("rst_drop", 32'(bus.drop_count), 32'd0);
      check32("rst_level", 32'(bus.fifo_level), 32'd0);
      @(negedge hash_clk);
      @(negedge hash_clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_burst(input string name);
      logic [31:0] want;
      check32({name, "_count"}, 32'(pulse_log.size()), 32'd4);
      for (int k = 0; k < 4 && k < pulse_log.size(); k++) begin
         want = 32'hA0 + 32'(k) - ADJ;
         check32({name, "_order"}, pulse_log[k], want);
         if (k > 0) check32({name, "_gap"}, 32'(pulse_cyc[k] - pulse_cyc[k-1]), 32'(HO + 1));
      end
   endtask

   // scoreboard monitor, away from the active edge
   always @(negedge hash_clk) begin
      logic [31:0] want;
      cyc++;
      check32("mon_pulse", 32'(bus.tx_new_nonce), 32'(m_pulse));
      if (bus.tx_new_nonce === 1'b1) begin
         pulse_log.push_back(bus.tx_golden_nonce);
         pulse_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check32("mon_unexpected_pulse", 32'd1, 32'd0);
         end else begin
            want = exp_q.pop_front();
            check32("mon_value", bus.tx_golden_nonce, want);
         end
      end
      check32("mon_drop", 32'(bus.drop_count), 32'(m_drop));
      check32("mon_level", 32'(bus.fifo_level), 32'(m_fifo.size()));
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [32*NC-1:0] v;
      logic [NC-1:0]    s;
      int               sent;
      int               strobe_cyc;

      bus.in_new_nonce    = '0;
      bus.in_golden_nonce = '0;
      bus.tx_busy         = 1'b0;
      model_reset();
      @(negedge hash_clk);
      #1;
      do_reset();

      // simultaneous strobes from all cores, twice
      for (int b = 0; b < 2; b++) begin
         pulse_log.delete();
         pulse_cyc.delete();
         cycle(4'hF, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
         drain("burst", 200);
         check_burst(b == 0 ? "burst0" : "burst1");
      end

      // single nonce latency and adjustment
      pulse_log.delete();
      pulse_cyc.delete();
      v = '0;
      v[31:0] = 32'h1234_5678;
      cycle(4'h1, v, 1'b0);
      strobe_cyc = cyc;
      drain("single", 100);
      check32("single_count", 32'(pulse_log.size()), 32'd1);
      if (pulse_cyc.size() > 0) check32("single_latency", 32'(pulse_cyc[0] - strobe_cyc), 32'd2);
      check32("single_value", bus.tx_golden_nonce, 32'h1234_55F8);
      check32("single_drop", 32'(bus.drop_count), 32'd0);

      // back-pressure fills the FIFO, then one strobe is dropped
      pulse_log.delete();
      for (int k = 0; k < 8; k++) begin
         v = '0;
         v[63:32] = 32'hB000 + 32'(k);
         cycle(4'h2, v, 1'b1);
         cycle('0, '0, 1'b1);
      end
      check32("bp_full_level", 32'(bus.fifo_level), 32'd8);
      v[63:32] = 32'hB008;
      cycle(4'h2, v, 1'b1);
      cycle('0, '0, 1'b1);
      v[63:32] = 32'hB009;
      cycle(4'h2, v, 1'b1);
      idle(3, 1'b1);
      check32("bp_drop", 32'(bus.drop_count), 32'd1);
      check32("bp_no_pulse", 32'(pulse_log.size()), 32'd0);
      drain("bp", 300);
      check32("bp_pulses", 32'(pulse_log.size()), 32'd9);
      check32("bp_empty", 32'(bus.fifo_level), 32'd0);

      // grant and new strobe on the same edge
      pulse_log.delete();
      v = '0;
      v[95:64] = 32'h11;
      cycle(4'h4, v, 1'b0);
      v[95:64] = 32'h22;
      cycle(4'h4, v, 1'b0);
      drain("same_edge", 100);
      check32("same_edge_count", 32'(pulse_log.size()), 32'd2);
      if (pulse_log.size() == 2) begin
         check32("same_edge_first", pulse_log[0], 32'h11 - ADJ);
         check32("same_edge_second", pulse_log[1], 32'h22 - ADJ);
      end
      check32("same_edge_drop", 32'(bus.drop_count), 32'd1);

      // 300 random nonces streamed, tx_busy low
      sent = 0;
      while (sent < 300) begin
         s = '0;
         v = '0;
         for (int i = 0; i < NC; i++) begin
            if ($urandom_range(39) == 0) begin
               s[i] = 1'b1;
               v[32*i +: 32] = $urandom();
               sent++;
            end
         end
         cycle(s, v, 1'b0);
      end
      drain("stream", 5000);

      // random mix with busy toggling
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < NC; i++) begin
            s[i] = ($urandom_range(9) == 0);
            v[32*i +: 32] = $urandom();
         end
         cycle(s, v, ($urandom_range(3) == 0));
      end
      drain("mixed", 5000);

      // drop counter saturation
      for (int k = 0; k < 320; k++) begin
         v = '0;
         v[31:0] = $urandom();
         cycle(4'h1, v, 1'b1);
      end
      check32("sat_drop", 32'(bus.drop_count), 32'd255);
      drain("sat", 500);

      // reset while nonces are buffered and the FSM is holding
      v = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
      cycle(4'hF, v, 1'b0);
      v[31:0] = 32'hC4;
      cycle(4'h1, v, 1'b0);
      idle(2, 1'b0);
      check32("midrst_pulsed", 32'(pulse_log.size() > 0), 32'd1);
      pulse_log.delete();
      do_reset();
      idle(30, 1'b0);
      check32("midrst_quiet", 32'(pulse_log.size()), 32'd0);
      check32("midrst_level", 32'(bus.fifo_level), 32'd0);

      check32("final_sb_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
